// File: rtl/debug_pipe_ctrl.sv
// rtl/debug_pipe_ctrl.sv - debug-unit controller: program load, run/step and drain of the pipeline
`ifndef ADDRWIDTH
`define ADDRWIDTH 5
`endif
`ifndef N_ELEMENTS
`define N_ELEMENTS 32
`endif

module debug_pipe_ctrl #(
  parameter int NB_INST    = 32,
  parameter int NB_ADDR    = `ADDRWIDTH,
  parameter int MEM_SIZEB  = `N_ELEMENTS,
  parameter int PIPE_DRAIN = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_rx_valid,
  input  logic [7:0]         i_rx_byte,
  input  logic [NB_INST-1:0] i_fetch_instr,
  output logic               o_debug_unit,
  output logic               o_mem_wen,
  output logic               o_mem_ren,
  output logic [NB_INST-1:0] o_mem_data,
  output logic [NB_ADDR-1:0] o_wr_addr,
  output logic               o_enable_pipe,
  output logic               o_pipe_clear,
  output logic               o_load_done,
  output logic               o_halted,
  output logic               o_error,
  output logic [31:0]        o_cycle_count
);

  localparam logic [5:0] HALT_OP = 6'b111111;
  localparam logic [7:0] CMD_L   = 8'h4C;
  localparam logic [7:0] CMD_R   = 8'h52;
  localparam logic [7:0] CMD_S   = 8'h53;
  localparam int NBYTES = NB_INST / 8;
  localparam int BC_W   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int DW     = $clog2(PIPE_DRAIN + 1);
  localparam logic [BC_W-1:0]    LAST_BYTE  = BC_W'(NBYTES - 1);
  localparam logic [DW-1:0]      LAST_DRAIN = DW'(PIPE_DRAIN - 1);
  localparam logic [NB_ADDR-1:0] LAST_ADDR  = NB_ADDR'(MEM_SIZEB - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_CLEAR,
    ST_RUN,
    ST_STEP,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t              state;
  logic [NB_INST-9:0]  asm_reg;    // bytes of the word being assembled, MSB first
  logic [BC_W-1:0]     byte_cnt;
  logic                run_mode;   // remembers whether CLEAR leads to RUN or STEP
  logic [DW-1:0]       drain_cnt;

  logic rx_l, rx_r, rx_s;
  logic fetch_halt, wr_halt;
  logic fetch_unused;

  assign rx_l       = i_rx_valid && (i_rx_byte == CMD_L);
  assign rx_r       = i_rx_valid && (i_rx_byte == CMD_R);
  assign rx_s       = i_rx_valid && (i_rx_byte == CMD_S);
  assign fetch_halt = (i_fetch_instr[NB_INST-1 -: 6] == HALT_OP);
  assign wr_halt    = (o_mem_data[NB_INST-1 -: 6] == HALT_OP);
  assign fetch_unused = ^i_fetch_instr[NB_INST-7:0];

  // Controller FSM with all outputs registered; write strobe and enable live in disjoint states
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= ST_IDLE;
      asm_reg       <= '0;
      byte_cnt      <= '0;
      run_mode      <= 1'b0;
      drain_cnt     <= '0;
      o_debug_unit  <= 1'b0;
      o_mem_wen     <= 1'b0;
      o_mem_ren     <= 1'b1;
      o_mem_data    <= '0;
      o_wr_addr     <= '0;
      o_enable_pipe <= 1'b0;
      o_pipe_clear  <= 1'b0;
      o_load_done   <= 1'b0;
      o_halted      <= 1'b0;
      o_error       <= 1'b0;
      o_cycle_count <= '0;
    end else begin
      o_pipe_clear <= 1'b0;
      o_mem_wen    <= 1'b0;
      if (o_enable_pipe && (o_cycle_count != 32'hFFFF_FFFF)) begin
        o_cycle_count <= o_cycle_count + 32'd1;
      end

      case (state)
        ST_IDLE, ST_DONE: begin
          if (rx_l) begin
            state        <= ST_LOAD;
            o_debug_unit <= 1'b1;
            o_mem_ren    <= 1'b0;
            o_load_done  <= 1'b0;
            o_halted     <= 1'b0;
            o_error      <= 1'b0;
            o_wr_addr    <= '0;
            byte_cnt     <= '0;
          end else if ((rx_r || rx_s) && o_load_done) begin
            state         <= ST_CLEAR;
            o_pipe_clear  <= 1'b1;
            o_cycle_count <= '0;
            o_halted      <= 1'b0;
            run_mode      <= rx_r;
          end
        end

        ST_LOAD: begin
          // Assembly keeps going while the previous word is being written
          if (i_rx_valid) begin
            if (byte_cnt == LAST_BYTE) begin
              o_mem_data <= {asm_reg, i_rx_byte};
              o_mem_wen  <= 1'b1;
              byte_cnt   <= '0;
            end else begin
              asm_reg  <= {asm_reg[NB_INST-17:0], i_rx_byte};
              byte_cnt <= byte_cnt + BC_W'(1);
            end
          end
          if (o_mem_wen) begin
            if (wr_halt) begin
              state        <= ST_IDLE;
              o_load_done  <= 1'b1;
              o_debug_unit <= 1'b0;
              o_mem_ren    <= 1'b1;
            end else if (o_wr_addr == LAST_ADDR) begin
              state        <= ST_IDLE;
              o_error      <= 1'b1;
              o_debug_unit <= 1'b0;
              o_mem_ren    <= 1'b1;
            end else begin
              o_wr_addr <= o_wr_addr + NB_ADDR'(1);
            end
          end
        end

        ST_CLEAR: begin
          // Run starts enabled; step starts with the single step of the accepting 'S'
          o_enable_pipe <= 1'b1;
          state         <= run_mode ? ST_RUN : ST_STEP;
        end

        ST_RUN: begin
          if (o_enable_pipe && fetch_halt) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end
        end

        ST_STEP: begin
          if (o_enable_pipe && fetch_halt) begin
            state     <= ST_DRAIN;
            drain_cnt <= '0;
          end else if (rx_r) begin
            state         <= ST_RUN;
            o_enable_pipe <= 1'b1;
          end else begin
            o_enable_pipe <= rx_s;
          end
        end

        ST_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state         <= ST_DONE;
            o_enable_pipe <= 1'b0;
            o_halted      <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end

        default: begin
          state         <= ST_IDLE;
          o_enable_pipe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_pipe_ctrl.sv
// tb/tb_debug_pipe_ctrl.sv - self-checking bench for debug_pipe_ctrl
module tb_debug_pipe_ctrl;

  localparam int NB_INST   = 32;
  localparam int NB_ADDR   = 5;
  localparam int MEM_SIZEB = 32;
  localparam int PDRAIN    = 4;
  localparam logic [7:0]  CMD_L  = 8'h4C;
  localparam logic [7:0]  CMD_R  = 8'h52;
  localparam logic [7:0]  CMD_S  = 8'h53;
  localparam logic [31:0] HALT_W = 32'hFC00_0000;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               rx_valid;
  logic [7:0]         rx_byte;
  logic [NB_INST-1:0] fetch_instr;
  logic               debug_unit, mem_wen, mem_ren;
  logic [NB_INST-1:0] mem_data;
  logic [NB_ADDR-1:0] wr_addr;
  logic               enable_pipe, pipe_clear, load_done, halted, error;
  logic [31:0]        cycle_count;

  int checks = 0;
  int errors = 0;

  // observation log kept by the monitor
  logic [31:0] wq_data[$];
  int          wq_addr[$];
  int          en_cnt = 0, en_pulses = 0, clr_cnt = 0, overlap_cnt = 0;
  logic        prev_en = 1'b0;

  debug_pipe_ctrl #(
    .NB_INST(NB_INST), .NB_ADDR(NB_ADDR), .MEM_SIZEB(MEM_SIZEB), .PIPE_DRAIN(PDRAIN)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_rx_valid(rx_valid), .i_rx_byte(rx_byte),
    .i_fetch_instr(fetch_instr), .o_debug_unit(debug_unit), .o_mem_wen(mem_wen),
    .o_mem_ren(mem_ren), .o_mem_data(mem_data), .o_wr_addr(wr_addr),
    .o_enable_pipe(enable_pipe), .o_pipe_clear(pipe_clear), .o_load_done(load_done),
    .o_halted(halted), .o_error(error), .o_cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_wen) begin
      wq_data.push_back(mem_data);
      wq_addr.push_back(int'(wr_addr));
    end
    if (mem_wen && enable_pipe) overlap_cnt++;
    if (enable_pipe) en_cnt++;
    if (enable_pipe && !prev_en) en_pulses++;
    if (pipe_clear) clr_cnt++;
    prev_en = enable_pipe;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_byte  = b;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      rx_valid = 1'b0;
    end
  endtask

  function automatic logic [31:0] rand_nonhalt();
    logic [31:0] w;
    w = $urandom;
    if (w[31:26] == 6'h3F) w[31] = 1'b0;
    return w;
  endfunction

  // sends words MSB first with random gaps; expected writes are the words in order at 0,1,2...
  task automatic load_prog(input int n_words, input bit end_halt, input int gap_max, input string tag);
    logic [31:0] w;
    logic [31:0] exp_q[$];
    int base;
    base = wq_data.size();
    for (int i = 0; i < n_words; i++) begin
      w = rand_nonhalt();
      if (end_halt && i == n_words - 1) w = HALT_W;
      exp_q.push_back(w);
      for (int b = 3; b >= 0; b--) begin
        put(w[b*8 +: 8]);
        idle($urandom_range(0, gap_max));
      end
    end
    idle(4);
    check({tag, " wen count"}, 64'(wq_data.size() - base), 64'(n_words));
    for (int i = 0; i < n_words && base + i < wq_data.size(); i++) begin
      check({tag, " addr"}, 64'(wq_addr[base+i]), 64'(i));
      check({tag, " data"}, 64'(wq_data[base+i]), 64'(exp_q[i]));
    end
  endtask

  int n_halt, seen, b_en, b_clr, b_pl;
  bit done;

  initial begin
    rst_n = 1'b0;
    rx_valid = 1'b0;
    rx_byte = 8'h00;
    fetch_instr = rand_nonhalt();
    idle(3);
    check("rst enable", enable_pipe, 0);
    check("rst mem_ren", mem_ren, 1);
    check("rst mem_wen", mem_wen, 0);
    check("rst debug", debug_unit, 0);
    check("rst load_done", load_done, 0);
    check("rst halted", halted, 0);
    check("rst error", error, 0);
    check("rst count", cycle_count, 0);
    check("rst addr", wr_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // run/step before any load are ignored
    b_clr = clr_cnt; b_en = en_cnt;
    put(CMD_R); idle(1); put(CMD_S); idle(4);
    check("preload clear", 64'(clr_cnt - b_clr), 0);
    check("preload enable", 64'(en_cnt - b_en), 0);

    // 11-word program ending with HALT
    put(CMD_L); idle(1);
    check("load debug", debug_unit, 1);
    check("load ren", mem_ren, 0);
    load_prog(11, 1'b1, 2, "load11");
    check("load11 done", load_done, 1);
    check("load11 error", error, 0);
    check("load11 debug", debug_unit, 0);
    check("load11 ren", mem_ren, 1);

    // continuous run, HALT fetched on enabled cycle n_halt
    n_halt = $urandom_range(3, 20);
    b_en = en_cnt; b_clr = clr_cnt; b_pl = en_pulses;
    seen = 0; done = 0;
    put(CMD_R);
    for (int c = 0; c < 300 && !done; c++) begin
      @(negedge clk);
      rx_valid = 1'b0;
      if (enable_pipe) seen++;
      fetch_instr = (enable_pipe && seen == n_halt) ? HALT_W : rand_nonhalt();
      if (halted) done = 1;
    end
    check("run reached halt", done, 1);
    idle(3);
    check("run clear pulses", 64'(clr_cnt - b_clr), 1);
    check("run enable cycles", 64'(en_cnt - b_en), 64'(n_halt + PDRAIN));
    check("run enable pulses", 64'(en_pulses - b_pl), 1);
    check("run count", cycle_count, 64'(n_halt + PDRAIN));
    check("run halted", halted, 1);
    check("run enable off", enable_pipe, 0);

    // re-run from DONE in step mode: three isolated single steps
    fetch_instr = rand_nonhalt();
    b_en = en_cnt; b_clr = clr_cnt; b_pl = en_pulses;
    for (int i = 0; i < 3; i++) begin
      put(CMD_S); idle(4);
    end
    check("step clear", 64'(clr_cnt - b_clr), 1);
    check("step enable cycles", 64'(en_cnt - b_en), 3);
    check("step pulses", 64'(en_pulses - b_pl), 3);
    check("step count", cycle_count, 3);
    check("step halted", halted, 0);

    // HALT present while idle in step is ignored; the next step fetches it and drains
    fetch_instr = HALT_W;
    idle(3);
    check("step idle halt ignored", enable_pipe, 0);
    b_en = en_cnt;
    put(CMD_S); idle(10);
    check("step halt enable cycles", 64'(en_cnt - b_en), 64'(1 + PDRAIN));
    check("step halt count", cycle_count, 64'(3 + 1 + PDRAIN));
    check("step halted", halted, 1);
    fetch_instr = rand_nonhalt();

    // back-to-back bytes
    put(CMD_L);
    load_prog(7, 1'b1, 0, "b2b");
    check("b2b done", load_done, 1);
    check("b2b halted cleared", halted, 0);

    // overflow: whole memory filled without HALT
    put(CMD_L);
    load_prog(MEM_SIZEB, 1'b0, 1, "ovf");
    check("ovf error", error, 1);
    check("ovf load_done", load_done, 0);
    check("ovf last addr", wr_addr, 64'(MEM_SIZEB - 1));
    check("ovf debug", debug_unit, 0);
    b_clr = clr_cnt;
    put(CMD_R); idle(4);
    check("ovf run ignored", 64'(clr_cnt - b_clr), 0);

    // asynchronous reset in the middle of a run
    put(CMD_L);
    load_prog(1, 1'b1, 0, "one");
    check("one done", load_done, 1);
    put(CMD_R); idle(6);
    check("midrun enable", enable_pipe, 1);
    #3 rst_n = 1'b0;
    #1;
    check("async enable", enable_pipe, 0);
    check("async halted", halted, 0);
    check("async load_done", load_done, 0);
    check("async ren", mem_ren, 1);
    check("async count", cycle_count, 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    check("no wen/enable overlap", 64'(overlap_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
